ov7670_init_seq: RTL and testbench

Sequencer that brings up the OV7670 after power-on. It walks the camera register table from index 0, reads each 17-bit entry {reg_addr, reg_value, rw_flag}, and issues one SCCB transaction per entry through a req/done handshake to the SCCB master. It stops at the 16'hffff sentinel. It sits between the register table (upstream) and the SCCB master (downstream), and reports done/error status to the capture pipeline.

---
 rtl/ov7670_init_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_ov7670_init_seq.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_init_seq.sv
// OV7670 power-on register sequencer.
// Walks the camera register table from index 0 and issues one SCCB transaction per entry.
// It stops at the 16'hffff sentinel, or after the last entry (index 127).
// Failed attempts (NACK or timeout) are retried a bounded number of times before aborting.
module ov7670_init_seq #(
    parameter int unsigned STARTUP_CYCLES = 1_000_000,
    parameter int unsigned SETTLE_CYCLES  = 12_000,
    parameter int unsigned TIMEOUT_CYCLES = 65_535,
    parameter int unsigned MAX_RETRY      = 3,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic [6:0]  index_o,
    input  logic [16:0] rom_data_i,
    output logic        sccb_req_o,
    output logic [7:0]  sccb_addr_o,
    output logic [7:0]  sccb_data_o,
    output logic        sccb_rw_o,
    input  logic        sccb_done_i,
    input  logic        sccb_nack_i,
    input  logic [7:0]  sccb_rdata_i,
    output logic [7:0]  last_rd_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [6:0]  err_index_o
);

    // Terminal count of a 0-based cycle counter; a zero-length wait still takes one cycle.
    function automatic logic [19:0] last_count(input int unsigned cycles);
        if (cycles == 0) begin
            return 20'd0;
        end
        return 20'(cycles - 1);
    endfunction

    localparam logic [19:0] StartupLast = last_count(STARTUP_CYCLES);
    localparam logic [19:0] SettleLast  = last_count(SETTLE_CYCLES);
    localparam logic [19:0] TimeoutLast = last_count(TIMEOUT_CYCLES);
    localparam logic [7:0]  MaxRetry    = 8'(MAX_RETRY);
    localparam logic [7:0]  SoftResetReg = 8'h12;

    typedef enum logic [2:0] {
        StIdle,
        StPowerup,
        StFetch,
        StIssue,
        StWait,
        StSettle,
        StDone,
        StFail
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  index_q, index_d;
    logic [19:0] cnt_q, cnt_d;
    logic [7:0]  retry_q, retry_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        rw_q, rw_d;
    logic        req_q, req_d;
    logic [7:0]  last_rd_q, last_rd_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [6:0]  err_index_q, err_index_d;

    // Per-cycle events raised by the state decode and resolved once below.
    logic        do_start;
    logic        do_advance;
    logic        do_fail;
    logic        soft_reset_write;

    // A write of bit7 to COM7 resets the sensor, which then needs time before the next access.
    assign soft_reset_write = rw_q && (addr_q == SoftResetReg) && data_q[7];

    // State register and all holding registers; reset returns everything to IDLE with zeros.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            index_q     <= 7'd0;
            cnt_q       <= 20'd0;
            retry_q     <= 8'd0;
            addr_q      <= 8'd0;
            data_q      <= 8'd0;
            rw_q        <= 1'b0;
            req_q       <= 1'b0;
            last_rd_q   <= 8'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= 7'd0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rw_q        <= rw_d;
            req_q       <= req_d;
            last_rd_q   <= last_rd_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rw_d        = rw_q;
        req_d       = req_q;
        last_rd_d   = last_rd_q;
        done_d      = done_q;
        error_d     = error_q;
        err_index_d = err_index_q;
        do_start    = 1'b0;
        do_advance  = 1'b0;
        do_fail     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (AUTO_START || start_i) begin
                    do_start = 1'b1;
                end
            end
            StPowerup: begin
                if (cnt_q >= StartupLast) begin
                    cnt_d   = 20'd0;
                    state_d = StFetch;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            StFetch: begin
                addr_d = rom_data_i[16:9];
                data_d = rom_data_i[8:1];
                rw_d   = rom_data_i[0];
                if (rom_data_i[16:1] == 16'hffff) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                req_d   = 1'b1;
                cnt_d   = 20'd0;
                state_d = StWait;
            end
            StWait: begin
                // A completion in the same cycle as the timeout takes precedence.
                if (sccb_done_i) begin
                    req_d = 1'b0;
                    cnt_d = 20'd0;
                    if (sccb_nack_i) begin
                        do_fail = 1'b1;
                    end else begin
                        if (!rw_q) begin
                            last_rd_d = sccb_rdata_i;
                        end
                        if (soft_reset_write) begin
                            state_d = StSettle;
                        end else begin
                            do_advance = 1'b1;
                        end
                    end
                end else if (cnt_q >= TimeoutLast) begin
                    req_d   = 1'b0;
                    cnt_d   = 20'd0;
                    do_fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            StSettle: begin
                if (cnt_q >= SettleLast) begin
                    cnt_d      = 20'd0;
                    do_advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            StDone, StFail: begin
                if (start_i) begin
                    do_start = 1'b1;
                end
            end
        endcase

        if (do_start) begin
            index_d = 7'd0;
            done_d  = 1'b0;
            error_d = 1'b0;
            retry_d = 8'd0;
            cnt_d   = 20'd0;
            state_d = StPowerup;
        end

        // Entry completed: move on, but the index saturates at the end of the table.
        if (do_advance) begin
            retry_d = 8'd0;
            if (index_q == 7'd127) begin
                done_d  = 1'b1;
                state_d = StDone;
            end else begin
                index_d = index_q + 7'd1;
                state_d = StFetch;
            end
        end

        if (do_fail) begin
            if (retry_q < MaxRetry) begin
                retry_d = retry_q + 8'd1;
                state_d = StIssue;
            end else begin
                err_index_d = index_q;
                error_d     = 1'b1;
                state_d     = StFail;
            end
        end
    end

    // Status and SCCB outputs come straight from registers.
    always_comb begin
        index_o     = index_q;
        sccb_req_o  = req_q;
        sccb_addr_o = addr_q;
        sccb_data_o = data_q;
        sccb_rw_o   = rw_q;
        last_rd_o   = last_rd_q;
        done_o      = done_q;
        error_o     = error_q;
        err_index_o = err_index_q;
        busy_o      = !(state_q inside {StIdle, StDone, StFail});
    end

endmodule

// File: tb/tb_ov7670_init_seq.sv
// Self-checking bench for ov7670_init_seq: table ROM, SCCB responder and a transaction-level
// reference model that predicts every request (fields, gap, duration) and the final status.
module tb_ov7670_init_seq;

    localparam int StartupCyc = 10;
    localparam int SettleCyc  = 20;
    localparam int TimeoutCyc = 50;
    localparam int MaxRetry   = 3;

    localparam logic [1:0] RespAck    = 2'd0;
    localparam logic [1:0] RespNack   = 2'd1;
    localparam logic [1:0] RespSilent = 2'd2;

    typedef struct {
        int idx;
        int addr;
        int data;
        int rw;
        int gap;
        int dur;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  index;
    logic [16:0] rom_data;
    logic        sccb_req;
    logic [7:0]  sccb_addr;
    logic [7:0]  sccb_data;
    logic        sccb_rw;
    logic        sccb_done = 1'b0;
    logic        sccb_nack = 1'b0;
    logic [7:0]  sccb_rdata = 8'd0;
    logic [7:0]  last_rd;
    logic        busy;
    logic        done;
    logic        error;
    logic [6:0]  err_index;

    // Stimulus tables.
    logic [16:0] rom [128];
    logic [1:0]  resp_kind [128][MaxRetry+1];
    int          resp_lat [128][MaxRetry+1];
    logic [7:0]  rdata_tab [128];
    int          att_cnt [128];

    // Observation and prediction.
    req_t obs[$];
    req_t exp_q[$];
    int   cyc = 0;
    int   ref_edge = 0;
    int   stab_err = 0;
    int   both_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    int       exp_index;
    logic     exp_done;
    logic     exp_error;
    int       m_last_rd = 0;
    int       m_err_idx = 0;

    assign rom_data = rom[index];

    ov7670_init_seq #(
        .STARTUP_CYCLES (StartupCyc),
        .SETTLE_CYCLES  (SettleCyc),
        .TIMEOUT_CYCLES (TimeoutCyc),
        .MAX_RETRY      (MaxRetry),
        .AUTO_START     (1'b1)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .index_o      (index),
        .rom_data_i   (rom_data),
        .sccb_req_o   (sccb_req),
        .sccb_addr_o  (sccb_addr),
        .sccb_data_o  (sccb_data),
        .sccb_rw_o    (sccb_rw),
        .sccb_done_i  (sccb_done),
        .sccb_nack_i  (sccb_nack),
        .sccb_rdata_i (sccb_rdata),
        .last_rd_o    (last_rd),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .err_index_o  (err_index)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SCCB responder and request monitor, sampling and driving on the falling edge.
    initial begin
        logic       req_prev;
        req_t       cur;
        int         hold;
        logic [1:0] kind;
        int         lat;
        req_prev = 1'b0;
        hold = 0;
        kind = RespAck;
        lat = 1;
        cur = '{default: 0};
        forever begin
            @(negedge clk);
            sccb_done  = 1'b0;
            sccb_nack  = 1'b0;
            sccb_rdata = 8'($urandom);
            if (done && error) both_cnt++;
            if (sccb_req && !req_prev) begin
                cur.idx  = int'(index);
                cur.addr = int'(sccb_addr);
                cur.data = int'(sccb_data);
                cur.rw   = int'(sccb_rw);
                cur.gap  = cyc - ref_edge;
                hold = 0;
                kind = resp_kind[index][att_cnt[index]];
                lat  = resp_lat[index][att_cnt[index]];
                if (att_cnt[index] < MaxRetry) att_cnt[index]++;
            end
            if (sccb_req) begin
                if (hold > 0 && (cur.addr != int'(sccb_addr) || cur.data != int'(sccb_data) ||
                                 cur.rw != int'(sccb_rw) || cur.idx != int'(index))) begin
                    stab_err++;
                end
                hold++;
                if (kind != RespSilent && hold == lat) begin
                    sccb_done  = 1'b1;
                    sccb_nack  = (kind == RespNack);
                    sccb_rdata = rdata_tab[cur.idx];
                end
            end
            if (!sccb_req && req_prev) begin
                cur.dur  = hold;
                ref_edge = cyc;
                obs.push_back(cur);
            end
            req_prev = sccb_req;
        end
    end

    // Reference model: walk the table, applying the retry and termination rules per entry.
    task automatic run_model();
        int   idx;
        int   gap;
        logic fin;
        logic ok;
        req_t e;
        idx = 0;
        gap = StartupCyc + 2;
        fin = 1'b0;
        exp_q.delete();
        while (!fin) begin
            if (rom[idx][16:1] == 16'hffff) begin
                exp_done = 1'b1; exp_error = 1'b0; exp_index = idx; fin = 1'b1;
            end else begin
                ok = 1'b0;
                for (int a = 0; a <= MaxRetry && !ok; a++) begin
                    e.idx  = idx;
                    e.addr = int'(rom[idx][16:9]);
                    e.data = int'(rom[idx][8:1]);
                    e.rw   = int'(rom[idx][0]);
                    e.gap  = gap;
                    e.dur  = (resp_kind[idx][a] == RespSilent) ? TimeoutCyc : resp_lat[idx][a];
                    exp_q.push_back(e);
                    if (resp_kind[idx][a] == RespAck) ok = 1'b1;
                    gap = 1;
                end
                if (!ok) begin
                    exp_done = 1'b0; exp_error = 1'b1; exp_index = idx; m_err_idx = idx;
                    fin = 1'b1;
                end else begin
                    if (!rom[idx][0]) m_last_rd = int'(rdata_tab[idx]);
                    gap = (rom[idx][0] && rom[idx][16:9] == 8'h12 && rom[idx][8]) ?
                          SettleCyc + 2 : 2;
                    if (idx == 127) begin
                        exp_done = 1'b1; exp_error = 1'b0; exp_index = 127; fin = 1'b1;
                    end else begin
                        idx++;
                    end
                end
            end
        end
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 128; i++) begin
            rom[i] = 17'h1ffff;
            rdata_tab[i] = 8'($urandom);
            for (int k = 0; k <= MaxRetry; k++) begin
                resp_kind[i][k] = RespAck;
                resp_lat[i][k] = 3;
            end
        end
    endtask

    task automatic set_entry(input int i, input logic [7:0] a, input logic [7:0] d,
                             input logic rw);
        rom[i] = {a, d, rw};
    endtask

    task automatic rand_setup();
        int         len;
        logic [7:0] a;
        int         r;
        clear_tables();
        len = $urandom_range(2, 10);
        for (int i = 0; i < len; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 8'h12 : 8'($urandom_range(0, 254));
            set_entry(i, a, 8'($urandom), 1'($urandom));
            for (int k = 0; k <= MaxRetry; k++) begin
                r = $urandom_range(0, 11);
                resp_kind[i][k] = (r < 8) ? RespAck : (r < 11) ? RespNack : RespSilent;
                resp_lat[i][k] = $urandom_range(1, 8);
            end
        end
        rom[len] = {16'hffff, 1'($urandom)};
    endtask

    // Launch one sequence (by reset release or by start_i), wait for it and compare.
    task automatic do_run(input string name, input bit by_reset);
        int n;
        @(negedge clk);
        if (by_reset) begin
            rst = 1'b1;
            repeat (3) @(negedge clk);
            m_last_rd = 0;
            m_err_idx = 0;
        end
        run_model();
        obs.delete();
        for (int i = 0; i < 128; i++) att_cnt[i] = 0;
        ref_edge = cyc + 1;
        if (by_reset) begin
            rst = 1'b0;
        end else begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_eq({name, " busy_early"}, busy, 1'b1);
        check_eq({name, " done_cleared"}, done, 1'b0);
        check_eq({name, " error_cleared"}, error, 1'b0);
        // A start pulse while busy must not disturb the sequence.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (n < 20000 && !(done || error)) begin
            @(negedge clk);
            n++;
        end
        check_eq({name, " finished"}, done | error, 1'b1);
        repeat (TimeoutCyc + 10) @(negedge clk);
        check_eq({name, " n_req"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            check_eq($sformatf("%s r%0d idx", name, i), obs[i].idx, exp_q[i].idx);
            check_eq($sformatf("%s r%0d addr", name, i), obs[i].addr, exp_q[i].addr);
            check_eq($sformatf("%s r%0d data", name, i), obs[i].data, exp_q[i].data);
            check_eq($sformatf("%s r%0d rw", name, i), obs[i].rw, exp_q[i].rw);
            check_eq($sformatf("%s r%0d gap", name, i), obs[i].gap, exp_q[i].gap);
            check_eq($sformatf("%s r%0d dur", name, i), obs[i].dur, exp_q[i].dur);
        end
        check_eq({name, " done"}, done, exp_done);
        check_eq({name, " error"}, error, exp_error);
        check_eq({name, " index"}, index, exp_index);
        check_eq({name, " err_index"}, err_index, m_err_idx);
        check_eq({name, " last_rd"}, last_rd, m_last_rd);
        check_eq({name, " busy_end"}, busy, 1'b0);
        check_eq({name, " req_end"}, sccb_req, 1'b0);
        check_eq({name, " stable"}, stab_err, 0);
        check_eq({name, " exclusive"}, both_cnt, 0);
    endtask

    initial begin
        int n;
        int cnt7;

        // Basic two-entry table.
        clear_tables();
        set_entry(0, 8'h3a, 8'h04, 1'b1);
        set_entry(1, 8'h40, 8'hd0, 1'b1);
        for (int i = 0; i < 2; i++) resp_lat[i][0] = 5;
        do_run("basic", 1'b1);
        check_eq("basic index2", index, 7'd2);

        // Soft reset write followed by another entry.
        clear_tables();
        set_entry(0, 8'h12, 8'h80, 1'b1);
        set_entry(1, 8'h11, 8'h01, 1'b1);
        do_run("settle", 1'b0);
        if (obs.size() > 1) check_eq("settle gap22", obs[1].gap, 22);

        // Two NACKs then ACK at index 5.
        clear_tables();
        for (int i = 0; i < 8; i++) set_entry(i, 8'(8'h20 + i), 8'(i * 3), 1'b1);
        resp_kind[5][0] = RespNack;
        resp_kind[5][1] = RespNack;
        do_run("retry", 1'b0);

        // Permanent NACK at index 7.
        clear_tables();
        for (int i = 0; i < 9; i++) set_entry(i, 8'(8'h30 + i), 8'(i), 1'b1);
        for (int k = 0; k <= MaxRetry; k++) resp_kind[7][k] = RespNack;
        do_run("nackfail", 1'b0);
        cnt7 = 0;
        foreach (obs[i]) if (obs[i].idx == 7) cnt7++;
        check_eq("nackfail req7", cnt7, 4);
        check_eq("nackfail erridx", err_index, 7'd7);

        // Restart from FAIL; entry 1 answers exactly at the timeout boundary; entry 2 silent.
        clear_tables();
        set_entry(0, 8'h01, 8'h11, 1'b1);
        set_entry(1, 8'h02, 8'h22, 1'b1);
        set_entry(2, 8'h03, 8'h33, 1'b1);
        resp_lat[1][0] = TimeoutCyc;
        for (int k = 0; k <= MaxRetry; k++) resp_kind[2][k] = RespSilent;
        do_run("timeout", 1'b0);

        // Read entry.
        clear_tables();
        set_entry(0, 8'h0a, 8'h00, 1'b0);
        set_entry(1, 8'h3a, 8'h04, 1'b1);
        set_entry(2, 8'h40, 8'hd0, 1'b1);
        rdata_tab[0] = 8'h76;
        do_run("read", 1'b0);
        check_eq("read last_rd76", last_rd, 8'h76);

        // Reset in the middle of WAIT.
        resp_lat[1][0] = 40;
        for (int i = 0; i < 128; i++) att_cnt[i] = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (n < 500 && !(sccb_req && index == 7'd1)) begin
            @(negedge clk);
            n++;
        end
        check_eq("midwait reached", sccb_req, 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst req", sccb_req, 1'b0);
        check_eq("rst index", index, 7'd0);
        check_eq("rst addr", sccb_addr, 8'd0);
        check_eq("rst data", sccb_data, 8'd0);
        check_eq("rst rw", sccb_rw, 1'b0);
        check_eq("rst last_rd", last_rd, 8'd0);
        check_eq("rst busy", busy, 1'b0);
        check_eq("rst done", done, 1'b0);
        check_eq("rst error", error, 1'b0);
        check_eq("rst err_index", err_index, 7'd0);
        resp_lat[1][0] = 3;
        do_run("after_rst", 1'b1);

        // Full table without sentinel: stops at index 127.
        clear_tables();
        for (int i = 0; i < 128; i++) begin
            set_entry(i, 8'($urandom_range(0, 254)), 8'($urandom), 1'($urandom));
            resp_lat[i][0] = 1;
        end
        do_run("full", 1'b0);

        // Randomized tables and responses.
        for (int r = 0; r < 8; r++) begin
            rand_setup();
            do_run($sformatf("rand%0d", r), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
